// File: rtl/globals_pkg.sv
`default_nettype none
// ============================================================================
// Package     : globals
// Description : Shared types and constants for the tile datapath: the
//               stream tag (Info) with its idle value, the global tile-row
//               limit, and the tile sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package globals;

    // Largest number of rows a single tile may hold.
    localparam int MAX_TILE_SIZE_M = 16;

    // Stream tag that travels alongside each operand row.
    typedef struct packed {
        logic       valid;
        logic       first_tile_k;
        logic       last_tile_k;
        logic       new_tile_k;
        logic [3:0] tag;
    } Info;

    localparam Info INIT_INFO = '{
        valid:        1'b0,
        first_tile_k: 1'b0,
        last_tile_k:  1'b0,
        new_tile_k:   1'b0,
        tag:          4'd0
    };

    // Tile sequencer FSM states.
    typedef enum logic [1:0] {
        TS_IDLE = 2'd0,
        TS_RUN  = 2'd1,
        TS_DONE = 2'd2
    } TileSeqState;

endpackage
`default_nettype wire

// File: rtl/tile_seq.sv
`default_nettype none
// ============================================================================
// Module      : tile_seq
// Description : Walks the rows of a tiled layer (m innermost, then k, then n)
//               and emits one operand-row address plus stream tag per cycle
//               while the downstream is ready.
// Ports       : clk, resetn (async, active low)
//               start                      - one-cycle launch pulse (IDLE only)
//               tile_size_m/num_tiles_k/n  - layer shape, sampled on start
//               en                         - downstream ready
//               info, rd_addr              - registered row tag and address
//               busy, done, err            - status; err flags a clamped
//                                            tile_size_m until next start
// Revision    : 1.0 - initial release
// ============================================================================
module tile_seq #(
    parameter int MAX_TILE_SIZE_M = globals::MAX_TILE_SIZE_M,
    parameter int MAX_TILES       = 1024
) (
    input  logic                                       clk,
    input  logic                                       resetn,
    input  logic                                       start,
    input  logic [$clog2(MAX_TILE_SIZE_M):0]           tile_size_m,
    input  logic [$clog2(MAX_TILES):0]                 num_tiles_k,
    input  logic [$clog2(MAX_TILES):0]                 num_tiles_n,
    input  logic                                       en,
    output globals::Info                               info,
    output logic [$clog2(MAX_TILE_SIZE_M*MAX_TILES):0] rd_addr,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       err
);

    localparam int M_W = $clog2(MAX_TILE_SIZE_M) + 1;
    localparam int K_W = $clog2(MAX_TILES) + 1;
    localparam int A_W = $clog2(MAX_TILE_SIZE_M * MAX_TILES) + 1;

    localparam logic [M_W-1:0] C_MAX_M = M_W'(MAX_TILE_SIZE_M);

    globals::TileSeqState state_q, state_d;

    logic [M_W-1:0] m_q, m_d;
    logic [K_W-1:0] k_q, k_d;
    logic [K_W-1:0] n_q, n_d;
    logic [A_W-1:0] addr_q, addr_d;
    logic           drain_q, drain_d;

    logic [M_W-1:0] cfg_m_q, cfg_m_d;
    logic [K_W-1:0] cfg_k_q, cfg_k_d;
    logic [K_W-1:0] cfg_n_q, cfg_n_d;

    globals::Info   info_q, info_d;
    logic [A_W-1:0] rd_addr_q, rd_addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           clamp;
    logic [M_W-1:0] tsm_sat;
    logic           cfg_zero;
    logic           issue;
    logic [M_W-1:0] eff_m;
    logic [K_W-1:0] eff_k;
    logic [K_W-1:0] eff_n;

    assign clamp    = (tile_size_m > C_MAX_M);
    assign tsm_sat  = clamp ? C_MAX_M : tile_size_m;
    assign cfg_zero = (tile_size_m == '0) || (num_tiles_k == '0) || (num_tiles_n == '0);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        k_d       = k_q;
        n_d       = n_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        cfg_m_d   = cfg_m_q;
        cfg_k_d   = cfg_k_q;
        cfg_n_d   = cfg_n_q;
        info_d    = globals::INIT_INFO;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        issue     = 1'b0;
        // The shape in force: live inputs on the accepting cycle so row 0
        // can issue right away, the latched copy afterwards.
        eff_m     = cfg_m_q;
        eff_k     = cfg_k_q;
        eff_n     = cfg_n_q;

        unique case (state_q)
            globals::TS_IDLE: begin
                if (start) begin
                    cfg_m_d = tsm_sat;
                    cfg_k_d = num_tiles_k;
                    cfg_n_d = num_tiles_n;
                    eff_m   = tsm_sat;
                    eff_k   = num_tiles_k;
                    eff_n   = num_tiles_n;
                    err_d   = clamp;
                    if (cfg_zero) begin
                        state_d = globals::TS_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = globals::TS_RUN;
                        busy_d  = 1'b1;
                        issue   = en;
                    end
                end
            end
            globals::TS_RUN: begin
                // drain_q marks that the final row is already on the output,
                // so done lands exactly one cycle after it.
                if (drain_q) begin
                    state_d = globals::TS_DONE;
                    drain_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    issue = en;
                end
            end
            globals::TS_DONE: begin
                state_d = globals::TS_IDLE;
            end
            default: begin
                state_d = globals::TS_IDLE;
            end
        endcase

        if (issue) begin
            info_d.valid        = 1'b1;
            info_d.first_tile_k = (k_q == '0);
            info_d.last_tile_k  = (k_q == eff_k - K_W'(1));
            info_d.new_tile_k   = (m_q == '0);
            // Row order matches linear address order, so the address is a
            // plain running count of issued rows.
            rd_addr_d           = addr_q;
            addr_d              = addr_q + A_W'(1);
            if (m_q == eff_m - M_W'(1)) begin
                m_d = '0;
                if (k_q == eff_k - K_W'(1)) begin
                    k_d = '0;
                    if (n_q == eff_n - K_W'(1)) begin
                        n_d     = '0;
                        addr_d  = '0;
                        drain_d = 1'b1;
                    end else begin
                        n_d = n_q + K_W'(1);
                    end
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end else begin
                m_d = m_q + M_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= globals::TS_IDLE;
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            addr_q    <= '0;
            drain_q   <= 1'b0;
            cfg_m_q   <= '0;
            cfg_k_q   <= '0;
            cfg_n_q   <= '0;
            info_q    <= globals::INIT_INFO;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            k_q       <= k_d;
            n_q       <= n_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            cfg_m_q   <= cfg_m_d;
            cfg_k_q   <= cfg_k_d;
            cfg_n_q   <= cfg_n_d;
            info_q    <= info_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign info    = info_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_seq
// Description : Self-checking bench for tile_seq. Expected rows are produced
//               from the layer shape with nested loops and plain arithmetic
//               and compared against every valid output row.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_seq;

    localparam int MAXM = globals::MAX_TILE_SIZE_M;
    localparam int MAXT = 64;
    localparam int M_W  = $clog2(MAXM) + 1;
    localparam int K_W  = $clog2(MAXT) + 1;
    localparam int A_W  = $clog2(MAXM * MAXT) + 1;

    logic           clk = 1'b0;
    logic           resetn;
    logic           start;
    logic [M_W-1:0] tile_size_m;
    logic [K_W-1:0] num_tiles_k;
    logic [K_W-1:0] num_tiles_n;
    logic           en;
    globals::Info   info;
    logic [A_W-1:0] rd_addr;
    logic           busy;
    logic           done;
    logic           err;

    typedef struct {
        int           addr;
        globals::Info inf;
    } row_t;

    row_t exp_q[$];
    int   n_checks       = 0;
    int   n_pass         = 0;
    int   cyc            = 0;
    int   start_cyc      = -100;
    int   last_valid_cyc = -1;
    int   rows_seen      = 0;
    int   en_mode        = 0;
    bit   active         = 1'b0;
    logic en_s           = 1'b1;

    tile_seq #(
        .MAX_TILE_SIZE_M(MAXM),
        .MAX_TILES      (MAXT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .tile_size_m(tile_size_m),
        .num_tiles_k(num_tiles_k),
        .num_tiles_n(num_tiles_n),
        .en         (en),
        .info       (info),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        en_s <= en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Downstream ready: always high, random, or a scripted 1,0,0,1 dip
    // two cycles into the layer.
    initial begin
        en = 1'b1;
        forever begin
            @(negedge clk);
            case (en_mode)
                1:       en = ($urandom_range(0, 3) != 0);
                2:       en = !((cyc - start_cyc) == 2 || (cyc - start_cyc) == 3);
                default: en = 1'b1;
            endcase
        end
    end

    // Row monitor: every valid row must be the next expected one.
    always @(negedge clk) begin
        row_t r;
        if (resetn && active && en_s == 1'b0)
            check("en_low_no_row", 32'(info.valid), 32'd0);
        if (resetn && info.valid) begin
            rows_seen++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_row", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(r.addr));
                check("info", 32'(info), 32'(r.inf));
            end
        end
    end

    function automatic int build_exp(input int m, input int k, input int n);
        int   em;
        row_t r;
        em = (m > MAXM) ? MAXM : m;
        exp_q.delete();
        if (m != 0 && k != 0 && n != 0) begin
            for (int nn = 0; nn < n; nn++)
                for (int kk = 0; kk < k; kk++)
                    for (int mm = 0; mm < em; mm++) begin
                        r.addr             = (nn * k + kk) * em + mm;
                        r.inf              = globals::INIT_INFO;
                        r.inf.valid        = 1'b1;
                        r.inf.first_tile_k = (kk == 0);
                        r.inf.last_tile_k  = (kk == k - 1);
                        r.inf.new_tile_k   = (mm == 0);
                        exp_q.push_back(r);
                    end
        end
        return exp_q.size();
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_info"}, 32'(info), 32'(globals::INIT_INFO));
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic launch(input int m, input int k, input int n, input int mode);
        @(negedge clk);
        start       = 1'b1;
        tile_size_m = M_W'(m);
        num_tiles_k = K_W'(k);
        num_tiles_n = K_W'(n);
        en_mode     = mode;
        start_cyc   = cyc;
        rows_seen   = 0;
        last_valid_cyc = -1;
        active      = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        // Shape must have been captured on start; scramble the inputs.
        tile_size_m = M_W'($urandom);
        num_tiles_k = K_W'($urandom);
        num_tiles_n = K_W'($urandom);
    endtask

    task automatic run_layer(input int m, input int k, input int n, input int mode, input bit poke);
        int rows;
        int t;
        rows = build_exp(m, k, n);
        launch(m, k, n, mode);
        check("busy_after_start", 32'(busy), 32'(rows != 0));
        if (poke) begin
            // A start while running must not disturb the layer.
            start = 1'b1; tile_size_m = 1; num_tiles_k = 1; num_tiles_n = 1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (done !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        active = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        if (rows == 0) check("done_latency", 32'(cyc - start_cyc), 32'd1);
        else           check("done_latency", 32'(cyc - last_valid_cyc), 32'd1);
        check("row_count", 32'(rows_seen), 32'(rows));
        check("rows_left", 32'(exp_q.size()), 32'd0);
        check("err", 32'(err), 32'(m > MAXM));
        check("busy_at_done", 32'(busy), 32'd0);
        // A start coinciding with done must be ignored.
        start = 1'b1; tile_size_m = 2; num_tiles_k = 1; num_tiles_n = 1;
        @(negedge clk);
        start = 1'b0;
        check("done_width", 32'(done), 32'd0);
        check("start_on_done_ignored", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic reset_mid_layer();
        int t;
        void'(build_exp(4, 3, 2));
        launch(4, 3, 2, 0);
        t = 0;
        while (!(info.valid === 1'b1 && rd_addr == A_W'(7)) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("row7_reached", 32'(rd_addr), 32'd7);
        #1;
        resetn = 1'b0;
        active = 1'b0;
        exp_q.delete();
        #1;
        check_idle("mid_reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(done), 32'd0);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        tile_size_m = '0;
        num_tiles_k = '0;
        num_tiles_n = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        resetn = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        run_layer(4, 3, 2, 0, 1'b0);        // 24-row reference layer
        run_layer(5, 1, 3, 0, 1'b0);        // single K-tile
        run_layer(4, 3, 2, 2, 1'b0);        // en dip mid-tile
        run_layer(4, 2, 0, 0, 1'b0);        // empty: no N-tiles
        run_layer(MAXM + 5, 2, 1, 0, 1'b0); // clamped tile size
        run_layer(3, 0, 2, 0, 1'b0);        // empty: no K-tiles
        run_layer(0, 2, 2, 0, 1'b0);        // empty: no rows
        run_layer(1, 1, 1, 0, 1'b0);        // single row
        reset_mid_layer();
        run_layer(4, 3, 2, 0, 1'b0);        // clean rerun after reset
        repeat (6)
            run_layer($urandom_range(2, 6), $urandom_range(1, 3), $urandom_range(2, 3), 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
